// File: rtl/joy_serial_reader_if.sv
// rtl/joy_serial_reader_if.sv - shifter-side bus of the serial joystick reader
interface joy_serial_reader_if;
   logic JOY_CLK;
   logic JOY_LOAD;
   logic JOY_DATA;

   // Reader drives the shifter clock and load, samples the serial data.
   modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
   // External parallel-to-serial shifter.
   modport slave  (input JOY_CLK, input JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/joy_serial_reader.sv
// rtl/joy_serial_reader.sv - serial JAMMA joystick deserialiser with frame debounce
module joy_serial_reader #(
   parameter int CLK_DIV    = 8,
   parameter int DEB_FRAMES = 2
) (
   input  logic                clk12,
   input  logic                pll_lckd,
   joy_serial_reader_if.master joy,
   output logic [11:0]         joystick1,
   output logic [11:0]         joystick2,
   output logic                frame_done,
   output logic                joy_update
);

   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [3:0] DEB_MAX   = 4'(DEB_FRAMES);
   localparam logic [4:0] SLOT_LAST = 5'd25;

   logic [7:0]  div_q, div_d;
   logic        joy_clk_q, joy_clk_d;
   logic        joy_load_q, joy_load_d;
   logic [4:0]  slot_q, slot_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic [23:0] shadow_q, shadow_d;
   logic [23:0] prev_q, prev_d;
   logic [3:0]  match_q, match_d;
   logic [11:0] j1_q, j1_d;
   logic [11:0] j2_q, j2_d;
   logic        frame_done_q, frame_done_d;
   logic        joy_update_q, joy_update_d;

   logic        wrap;
   logic        rise;
   logic        eof;
   logic [11:0] new_j1;
   logic [11:0] new_j2;

   // Divider, shifter clock/load, capture, frame compare and commit.
   always_comb begin
      wrap         = (div_q == DIV_LAST);
      rise         = wrap && !joy_clk_q;
      eof          = rise && (slot_q == SLOT_LAST);

      div_d        = wrap ? 8'd0 : div_q + 8'd1;
      joy_clk_d    = joy_clk_q ^ wrap;
      slot_d       = slot_q;
      joy_load_d   = joy_load_q;
      sync1_d      = joy.JOY_DATA;
      sync2_d      = sync1_q;
      shadow_d     = shadow_q;
      prev_d       = prev_q;
      match_d      = match_q;
      j1_d         = j1_q;
      j2_d         = j2_q;
      frame_done_d = eof;
      joy_update_d = 1'b0;

      if (rise) begin
         slot_d     = (slot_q == SLOT_LAST) ? 5'd0 : slot_q + 5'd1;
         joy_load_d = (slot_d != 5'd0);
         // Value sampled is the one settled before this JOY_CLK edge.
         if (slot_q >= 5'd2) begin
            shadow_d[slot_q - 5'd2] = sync2_q;
         end
      end

      // Frame bit f holds slot f+2; scatter into the two joystick words.
      new_j1 = {shadow_d[21], shadow_d[20], shadow_d[22], shadow_d[0],
                shadow_d[23], shadow_d[1],  shadow_d[2],  shadow_d[3],
                shadow_d[4],  shadow_d[5],  shadow_d[6],  shadow_d[7]};
      new_j2 = {shadow_d[17], shadow_d[16], shadow_d[18], shadow_d[8],
                shadow_d[19], shadow_d[9],  shadow_d[10], shadow_d[11],
                shadow_d[12], shadow_d[13], shadow_d[14], shadow_d[15]};

      if (eof) begin
         if (shadow_d == prev_q) begin
            match_d = (match_q >= DEB_MAX) ? DEB_MAX : match_q + 4'd1;
         end else begin
            match_d = 4'd1;
         end
         prev_d = shadow_d;
         if ((match_d == DEB_MAX) && ((new_j1 != j1_q) || (new_j2 != j2_q))) begin
            j1_d         = new_j1;
            j2_d         = new_j2;
            joy_update_d = 1'b1;
         end
      end
   end

   // State registers; reset puts the shifter in load and outputs at idle.
   always_ff @(posedge clk12 or negedge pll_lckd) begin
      if (!pll_lckd) begin
         div_q        <= 8'd0;
         joy_clk_q    <= 1'b0;
         joy_load_q   <= 1'b0;
         slot_q       <= 5'd0;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         shadow_q     <= '1;
         prev_q       <= '1;
         match_q      <= 4'd0;
         j1_q         <= 12'hFFF;
         j2_q         <= 12'hFFF;
         frame_done_q <= 1'b0;
         joy_update_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         joy_clk_q    <= joy_clk_d;
         joy_load_q   <= joy_load_d;
         slot_q       <= slot_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         shadow_q     <= shadow_d;
         prev_q       <= prev_d;
         match_q      <= match_d;
         j1_q         <= j1_d;
         j2_q         <= j2_d;
         frame_done_q <= frame_done_d;
         joy_update_q <= joy_update_d;
      end
   end

   assign joy.JOY_CLK  = joy_clk_q;
   assign joy.JOY_LOAD = joy_load_q;
   assign joystick1    = j1_q;
   assign joystick2    = j2_q;
   assign frame_done   = frame_done_q;
   assign joy_update   = joy_update_q;

endmodule
